// File: rtl/lockstep_compare_monitor_if.sv
// ---------------------------------------------------------------------------
// lockstep_compare_monitor_if
//   Bus bundle between the lockstep compare monitor and its environment
//   (the golden/netlist design copies and whoever reads the verdict).
//
//   master : the monitor itself. It drives stimulus, DUT reset and status,
//            and reads start, golden, netlist and mask.
//   slave  : the environment, the mirror image of master.
//
//   Signals:
//     start               run request (level sampled)
//     golden / netlist    outputs of the two design copies
//     mask                1 = bit takes part in the compare
//     stim                stimulus to both copies
//     dut_rst             active-high reset to both copies
//     busy / done / pass  run status and verdict
//     mismatch_cnt        saturating mismatch count
//     first_fail_*        first-mismatch capture (zero when not built)
// ---------------------------------------------------------------------------
interface lockstep_compare_monitor_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic [OUT_W-1:0] golden;
    logic [OUT_W-1:0] netlist;
    logic [OUT_W-1:0] mask;
    logic [IN_W-1:0]  stim;
    logic             dut_rst;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [CNT_W-1:0] first_fail_idx;
    logic [OUT_W-1:0] first_fail_golden;
    logic [OUT_W-1:0] first_fail_netlist;

    modport master (
        input  start, golden, netlist, mask,
        output stim, dut_rst, busy, done, pass, mismatch_cnt,
               first_fail_idx, first_fail_golden, first_fail_netlist
    );

    modport slave (
        output start, golden, netlist, mask,
        input  stim, dut_rst, busy, done, pass, mismatch_cnt,
               first_fail_idx, first_fail_golden, first_fail_netlist
    );
endinterface

// File: rtl/lockstep_compare_monitor.sv
// ---------------------------------------------------------------------------
// lockstep_compare_monitor
//   Self-checking harness for golden-vs-netlist lockstep equivalence runs.
//   A run holds both design copies in reset for RST_CYCLES cycles, then
//   feeds NUM_VECTORS pseudo-random vectors from a 32-bit Galois LFSR, each
//   held for PERIOD cycles. The masked outputs of the two copies are
//   compared on the last cycle of the reset phase (index 0) and on the last
//   cycle of every vector period (index 1..NUM_VECTORS). Mismatches are
//   counted with saturation; done/pass report the verdict.
//
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-low reset
//     bus  lockstep_compare_monitor_if.master (start, golden, netlist, mask
//          in; stim, dut_rst, busy, done, pass, mismatch_cnt,
//          first_fail_idx/golden/netlist out)
//
//   Build option:
//     LCM_FIRST_FAIL_CAPTURE_EN  when defined, the index and raw (unmasked)
//     golden/netlist buses of the first mismatch of a run are latched.
//     Otherwise the first_fail_* outputs are tied to zero.
// ---------------------------------------------------------------------------
module lockstep_compare_monitor #(
    parameter int          IN_W        = 32,
    parameter int          OUT_W       = 32,
    parameter int          NUM_VECTORS = 1000,
    parameter int          PERIOD      = 2,
    parameter int          RST_CYCLES  = 2,
    parameter int          CNT_W       = 16,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic                        clk,
    input  logic                        rst,
    lockstep_compare_monitor_if.master  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RST  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [31:0] POLY     = 32'h8020_0003;
    // An all-zero Galois LFSR is stuck, so a zero seed is replaced by 1.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    localparam int CYC_MAX = (RST_CYCLES > PERIOD) ? RST_CYCLES : PERIOD;
    localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam int VEC_W   = $clog2(NUM_VECTORS + 1);

    localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] PER_LAST = CYC_W'(PERIOD - 1);
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECTORS);

    logic [1:0]       state_q,   state_d;
    logic [CYC_W-1:0] cyc_q,     cyc_d;
    logic [VEC_W-1:0] vec_q,     vec_d;
    logic [31:0]      lfsr_q,    lfsr_d;
    logic [IN_W-1:0]  stim_q,    stim_d;
    logic             dut_rst_q, dut_rst_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             pass_q,    pass_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic [31:0]      lfsr_nxt;
    logic             mism;
    logic             rst_cmp;
    logic             run_cmp;
    logic             cmp;
    logic             launch;

    always_comb begin
        lfsr_nxt = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
        mism     = |((bus.golden ^ bus.netlist) & bus.mask);
        rst_cmp  = (state_q == S_RST) && (cyc_q == RST_LAST);
        run_cmp  = (state_q == S_RUN) && (cyc_q == PER_LAST);
        cmp      = rst_cmp || run_cmp;
        launch   = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start;
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        vec_d     = vec_q;
        lfsr_d    = lfsr_q;
        stim_d    = stim_q;
        dut_rst_d = dut_rst_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        cnt_d     = cnt_q;

        if (cmp && mism && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (launch) begin
                    state_d   = S_RST;
                    cyc_d     = '0;
                    vec_d     = '0;
                    lfsr_d    = SEED_EFF;
                    stim_d    = '0;
                    dut_rst_d = 1'b1;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    cnt_d     = '0;
                end
            end
            S_RST: begin
                cyc_d = cyc_q + 1'b1;
                if (rst_cmp) begin
                    state_d   = S_RUN;
                    cyc_d     = '0;
                    vec_d     = VEC_W'(1);
                    dut_rst_d = 1'b0;
                    stim_d    = lfsr_q[IN_W-1:0];
                end
            end
            default: begin // S_RUN
                cyc_d = cyc_q + 1'b1;
                if (run_cmp) begin
                    cyc_d = '0;
                    if (vec_q == VEC_LAST) begin
                        // Verdict includes the compare made on this edge.
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (cnt_d == '0);
                    end else begin
                        vec_d  = vec_q + 1'b1;
                        lfsr_d = lfsr_nxt;
                        stim_d = lfsr_nxt[IN_W-1:0];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            vec_q     <= '0;
            lfsr_q    <= SEED_EFF;
            stim_q    <= '0;
            dut_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            vec_q     <= vec_d;
            lfsr_q    <= lfsr_d;
            stim_q    <= stim_d;
            dut_rst_q <= dut_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.stim         = stim_q;
    assign bus.dut_rst      = dut_rst_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.mismatch_cnt = cnt_q;

`ifdef LCM_FIRST_FAIL_CAPTURE_EN
    logic             ff_seen_q, ff_seen_d;
    logic [CNT_W-1:0] ff_idx_q,  ff_idx_d;
    logic [OUT_W-1:0] ff_gold_q, ff_gold_d;
    logic [OUT_W-1:0] ff_net_q,  ff_net_d;

    always_comb begin
        ff_seen_d = ff_seen_q;
        ff_idx_d  = ff_idx_q;
        ff_gold_d = ff_gold_q;
        ff_net_d  = ff_net_q;
        if (launch) begin
            ff_seen_d = 1'b0;
            ff_idx_d  = '0;
            ff_gold_d = '0;
            ff_net_d  = '0;
        end else if (cmp && mism && !ff_seen_q) begin
            // The reset compare reports index 0; vec_q is still 0 there too
            // but the explicit select keeps the intent obvious.
            ff_seen_d = 1'b1;
            ff_idx_d  = rst_cmp ? '0 : CNT_W'(vec_q);
            ff_gold_d = bus.golden;
            ff_net_d  = bus.netlist;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ff_seen_q <= 1'b0;
            ff_idx_q  <= '0;
            ff_gold_q <= '0;
            ff_net_q  <= '0;
        end else begin
            ff_seen_q <= ff_seen_d;
            ff_idx_q  <= ff_idx_d;
            ff_gold_q <= ff_gold_d;
            ff_net_q  <= ff_net_d;
        end
    end

    assign bus.first_fail_idx     = ff_idx_q;
    assign bus.first_fail_golden  = ff_gold_q;
    assign bus.first_fail_netlist = ff_net_q;
`else
    assign bus.first_fail_idx     = '0;
    assign bus.first_fail_golden  = '0;
    assign bus.first_fail_netlist = '0;
`endif

endmodule

// File: tb/tb_lockstep_compare_monitor.sv
// ---------------------------------------------------------------------------
// tb_lockstep_compare_monitor
//   Bench for lockstep_compare_monitor. A small run (4 vectors, period 2,
//   2 reset cycles) is driven cycle by cycle; golden/netlist values are
//   chosen per vector by the bench, and the expected stimulus, mismatch
//   count, verdict and first-fail capture are derived from those choices.
//   A second instance with a 2-bit counter covers saturation.
// ---------------------------------------------------------------------------
module tb_lockstep_compare_monitor;

    localparam int NV  = 4;
    localparam int PER = 2;
    localparam int RC  = 2;
    localparam int RUN_LEN = RC + NV * PER;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lockstep_compare_monitor_if #(.IN_W(32), .OUT_W(32), .CNT_W(16)) b();
    lockstep_compare_monitor_if #(.IN_W(8),  .OUT_W(8),  .CNT_W(2))  b2();

    lockstep_compare_monitor #(
        .IN_W(32), .OUT_W(32), .NUM_VECTORS(NV), .PERIOD(PER),
        .RST_CYCLES(RC), .CNT_W(16), .SEED(32'h1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    lockstep_compare_monitor #(
        .IN_W(8), .OUT_W(8), .NUM_VECTORS(NV), .PERIOD(PER),
        .RST_CYCLES(RC), .CNT_W(2), .SEED(32'h1)
    ) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Per-vector choices for the current run: index 0 is the reset compare.
    logic [31:0] gold_v [0:NV];
    logic [31:0] err_v  [0:NV];

    typedef struct {
        logic [31:0] err;
        logic [31:0] mask;
        int          exp_cnt;
        bit          exp_pass;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_stim"},    b.stim, 0);
        chk({tag, "_dutrst"},  b.dut_rst, 1);
        chk({tag, "_busy"},    b.busy, 0);
        chk({tag, "_done"},    b.done, 0);
        chk({tag, "_pass"},    b.pass, 0);
        chk({tag, "_cnt"},     b.mismatch_cnt, 0);
        chk({tag, "_ffidx"},   b.first_fail_idx, 0);
        chk({tag, "_ffgold"},  b.first_fail_golden, 0);
        chk({tag, "_ffnet"},   b.first_fail_netlist, 0);
    endtask

    // One full run. pulse_e >= 0 raises start during that cycle of the run;
    // abort_e >= 0 pulls rst low during that cycle and ends the run there.
    task automatic run(input logic [31:0] mk, input int pulse_e, input int abort_e);
        logic [31:0] exp_stim;
        int          exp_cnt;
        int          ffv;
        int          v;

        exp_cnt = 0;
        ffv     = -1;
        for (int i = 0; i <= NV; i++) begin
            if ((err_v[i] & mk) != 32'h0) begin
                exp_cnt++;
                if (ffv < 0) ffv = i;
            end
        end
        exp_stim = 32'h1;

        @(negedge clk);
        b.mask    = mk;
        b.start   = 1'b1;
        b.golden  = gold_v[0];
        b.netlist = gold_v[0] ^ err_v[0];
        @(posedge clk);                 // edge k
        @(negedge clk);
        b.start = 1'b0;
        chk("launch_busy",   b.busy, 1);
        chk("launch_dutrst", b.dut_rst, 1);
        chk("launch_done",   b.done, 0);
        chk("launch_cnt",    b.mismatch_cnt, 0);

        for (int e = 0; e < RUN_LEN; e++) begin
            v = (e < RC) ? 0 : (e - RC) / PER + 1;
            if (e == abort_e) begin
                rst = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk_reset_vals("abort");
                rst = 1'b1;
                return;
            end
            b.golden  = gold_v[v];
            b.netlist = gold_v[v] ^ err_v[v];
            b.start   = (e == pulse_e);
            if (e > RC && (e - RC) % PER == 0)
                exp_stim = lfsr_step(exp_stim);
            if (e == 0 || (e >= RC && (e - RC) % PER == 0)) begin
                chk("stim",    b.stim, (v == 0) ? 32'h0 : exp_stim);
                chk("dut_rst", b.dut_rst, (v == 0) ? 1 : 0);
            end
            if (e == RUN_LEN - 1)
                chk("done_early", b.done, 0);
            @(posedge clk);
            @(negedge clk);
        end
        b.start = 1'b0;

        chk("end_done",   b.done, 1);
        chk("end_busy",   b.busy, 0);
        chk("end_dutrst", b.dut_rst, 0);
        chk("end_cnt",    b.mismatch_cnt, exp_cnt);
        chk("end_pass",   b.pass, (exp_cnt == 0) ? 1 : 0);
        chk("end_stim",   b.stim, exp_stim);
`ifdef LCM_FIRST_FAIL_CAPTURE_EN
        chk("ff_idx",  b.first_fail_idx,     (ffv < 0) ? 0 : ffv);
        chk("ff_gold", b.first_fail_golden,  (ffv < 0) ? 32'h0 : gold_v[ffv]);
        chk("ff_net",  b.first_fail_netlist, (ffv < 0) ? 32'h0 : gold_v[ffv] ^ err_v[ffv]);
`else
        chk("ff_idx",  b.first_fail_idx, 0);
        chk("ff_gold", b.first_fail_golden | b.first_fail_netlist, 0);
`endif
    endtask

    task automatic fill(input logic [31:0] err);
        for (int i = 0; i <= NV; i++) begin
            gold_v[i] = $urandom;
            err_v[i]  = err;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        b.start = 1'b0; b.golden = '0; b.netlist = '0; b.mask = '1;
        b2.start = 1'b0; b2.golden = 8'h00; b2.netlist = 8'h01; b2.mask = 8'hFF;

        tbl[0] = '{32'h0,         32'hFFFF_FFFF, 0, 1'b1};
        tbl[1] = '{32'h8,         32'hFFFF_FFFF, 5, 1'b0};
        tbl[2] = '{32'h8,         ~32'h8,        0, 1'b1};
        tbl[3] = '{32'h100,       32'h0000_00FF, 0, 1'b1};
        tbl[4] = '{32'hFFFF_0000, 32'h0001_0000, 5, 1'b0};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", b.busy, 0);
        chk("idle_stim", b.stim, 0);

        for (int i = 0; i < 5; i++) begin
            fill(tbl[i].err);
            run(tbl[i].mask, -1, -1);
            chk("tbl_cnt",  b.mismatch_cnt, tbl[i].exp_cnt);
            chk("tbl_pass", b.pass, tbl[i].exp_pass);
        end

        // start during RUN is ignored; timing is checked inside run
        fill(32'h0);
        err_v[3] = 32'h40;
        run(32'hFFFF_FFFF, RC + 1, -1);

        // rst during vector 2 with mismatches pending, then a clean rerun
        fill(32'h8);
        run(32'hFFFF_FFFF, -1, RC + PER);
        fill(32'h0);
        run(32'hFFFF_FFFF, -1, -1);

        // randomized runs against the per-vector model
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i <= NV; i++) begin
                gold_v[i] = $urandom;
                err_v[i]  = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
            end
            run(($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom, -1, -1);
        end

        // 2-bit counter saturation: 5 compares all mismatch
        @(negedge clk);
        b2.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b2.start = 1'b0;
        repeat (RUN_LEN) @(negedge clk);
        chk("sat_done", b2.done, 1);
        chk("sat_cnt",  b2.mismatch_cnt, 3);
        chk("sat_pass", b2.pass, 0);
`ifdef LCM_FIRST_FAIL_CAPTURE_EN
        chk("sat_ffidx", b2.first_fail_idx, 0);
        chk("sat_ffxor", b2.first_fail_golden ^ b2.first_fail_netlist, 8'h01);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
